pwm_multi_peripheral: RTL and testbench

PWM_MULTI_PERIPHERAL -- requirements
Module: pwm_multi_peripheral

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_timebase.sv | 113 +++++++++++
 rtl/pwm_multi_peripheral.sv | 104 ++++++++++
 tb/tb_pwm_multi_peripheral.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM peripheral.
// Holds the register address map, MODE and counter-direction encodings,
// and the channel-count legality check used at elaboration.
package pwm_pkg;

    // Write-only register map (byte addresses)
    localparam logic [7:0] AddrEnOut = 8'h00;  // 0x00-0x03, one byte per 8 channels
    localparam logic [7:0] AddrEnPwm = 8'h04;  // 0x04-0x07
    localparam logic [7:0] AddrPresc = 8'h08;
    localparam logic [7:0] AddrTop   = 8'h09;
    localparam logic [7:0] AddrMode  = 8'h0A;
    localparam logic [7:0] AddrDuty  = 8'h10;  // 0x10 + channel

    typedef enum logic {
        ModeEdge   = 1'b0,
        ModeCenter = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } pwm_dir_e;

    function automatic bit num_ch_legal(input int unsigned n);
        return (n == 8) || (n == 16) || (n == 24) || (n == 32);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter, count direction and the
// period_tick pulse.
//   clk, rst     : clock, synchronous active-high reset
//   presc        : prescaler reload; a tick occurs every presc+1 cycles
//   presc_clr    : restart the prescaler count (PRESC register written)
//   top          : counter TOP value
//   mode         : edge- or center-aligned counting
//   cnt          : current counter value
//   boundary     : combinational, high on the tick where the counter returns to 0
//   period_tick  : registered copy of boundary (cycle after the boundary tick)
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] presc,
    input  logic               presc_clr,
    input  logic [CNT_W-1:0]   top,
    input  pwm_mode_e          mode,
    output logic [CNT_W-1:0]   cnt,
    output logic               boundary,
    output logic               period_tick
);

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    pwm_dir_e           dir_q, dir_d;
    pwm_mode_e          mode_seen_q, mode_seen_d;  // mode the counter is running in
    logic               period_tick_q;
    logic               tick;

    assign tick = (presc_cnt_q == presc);

    always_comb begin
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        if (presc_clr) begin
            presc_cnt_d = '0;
        end

        cnt_d       = cnt_q;
        dir_d       = dir_q;
        mode_seen_d = mode_seen_q;
        boundary    = 1'b0;

        if (tick) begin
            if (mode != mode_seen_q) begin
                // Mode switch restarts the count but does not end a period
                cnt_d       = '0;
                dir_d       = DirUp;
                mode_seen_d = mode;
            end else if (cnt_q > top) begin
                // TOP was lowered beneath the running count
                cnt_d    = '0;
                dir_d    = DirUp;
                boundary = 1'b1;
            end else if (mode == ModeEdge) begin
                if (cnt_q == top) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (top == '0) begin
                cnt_d    = '0;
                dir_d    = DirUp;
                boundary = 1'b1;
            end else if (dir_q == DirUp) begin
                if (cnt_q == top) begin
                    // TOP is held for a single tick, then start down
                    cnt_d = top - 1'b1;
                    if (top == CNT_W'(1)) begin
                        boundary = 1'b1;
                    end else begin
                        dir_d = DirDown;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d    = '0;
                    dir_d    = DirUp;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q   <= '0;
            cnt_q         <= '0;
            dir_q         <= DirUp;
            mode_seen_q   <= ModeEdge;
            period_tick_q <= 1'b0;
        end else begin
            presc_cnt_q   <= presc_cnt_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            mode_seen_q   <= mode_seen_d;
            period_tick_q <= boundary;
        end
    end

    assign cnt         = cnt_q;
    assign period_tick = period_tick_q;

endmodule

// File: rtl/pwm_multi_peripheral.sv
// Multi-channel PWM peripheral with a byte-wide write-only register port.
//   clk, rst     : clock, synchronous active-high reset
//   wr_valid     : register write strobe
//   wr_addr      : register address
//   wr_data      : register write data
//   out          : registered channel outputs
//   period_tick  : one-cycle pulse after each period boundary
// Duty values are double-buffered: writes land in a shadow register and are
// copied to the active register at each period boundary.
module pwm_multi_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [7:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_tick
);

    if (!num_ch_legal(NUM_CH)) begin : g_bad_num_ch
        $error("NUM_CH must be 8, 16, 24 or 32");
    end

    localparam int unsigned NumBytes = NUM_CH / 8;

    logic [NUM_CH-1:0]  en_out_q, en_pwm_q, out_q, out_d;
    logic [PRESC_W-1:0] presc_q;
    logic [CNT_W-1:0]   top_q, cnt;
    pwm_mode_e          mode_q;
    logic               boundary;

    logic wr_en_out, wr_en_pwm, wr_presc, wr_top, wr_mode;

    assign wr_en_out = wr_valid && (wr_addr[7:2] == AddrEnOut[7:2]);
    assign wr_en_pwm = wr_valid && (wr_addr[7:2] == AddrEnPwm[7:2]);
    assign wr_presc  = wr_valid && (wr_addr == AddrPresc);
    assign wr_top    = wr_valid && (wr_addr == AddrTop);
    assign wr_mode   = wr_valid && (wr_addr == AddrMode);

    always_ff @(posedge clk) begin
        if (rst) begin
            en_out_q <= '0;
            en_pwm_q <= '0;
            presc_q  <= '0;
            top_q    <= '0;
            mode_q   <= ModeEdge;
            out_q    <= '0;
        end else begin
            // Bytes past NumBytes simply have no matching slot
            for (int b = 0; b < NumBytes; b++) begin
                if (wr_en_out && (wr_addr[1:0] == 2'(b))) en_out_q[8*b +: 8] <= wr_data;
                if (wr_en_pwm && (wr_addr[1:0] == 2'(b))) en_pwm_q[8*b +: 8] <= wr_data;
            end
            if (wr_presc) presc_q <= PRESC_W'(wr_data);
            if (wr_top)   top_q   <= CNT_W'(wr_data);
            if (wr_mode)  mode_q  <= pwm_mode_e'(wr_data[0]);
            out_q <= out_d;
        end
    end

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .presc       (presc_q),
        .presc_clr   (wr_presc),
        .top         (top_q),
        .mode        (mode_q),
        .cnt         (cnt),
        .boundary    (boundary),
        .period_tick (period_tick)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] duty_shadow_q, duty_active_q;
        logic             wr_duty;

        assign wr_duty = wr_valid && (wr_addr == AddrDuty + 8'(c));

        always_ff @(posedge clk) begin
            if (rst) begin
                duty_shadow_q <= '0;
                duty_active_q <= '0;
            end else begin
                if (wr_duty) duty_shadow_q <= CNT_W'(wr_data);
                // A write on the boundary cycle goes straight through to active
                if (boundary) duty_active_q <= wr_duty ? CNT_W'(wr_data) : duty_shadow_q;
            end
        end

        assign out_d[c] = en_out_q[c] && (!en_pwm_q[c] || (cnt < duty_active_q));
    end

    assign out = out_q;

endmodule

// File: tb/tb_pwm_multi_peripheral.sv
// Directed bench for pwm_multi_peripheral. Expected {period_tick, out} values
// are queued as each step is driven and popped/compared at the negedge sample.
module tb_pwm_multi_peripheral;

    localparam int unsigned NumCh = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic [7:0]       wr_addr;
    logic [7:0]       wr_data;
    logic [NumCh-1:0] out;
    logic             period_tick;

    always #5 clk = ~clk;

    pwm_multi_peripheral #(
        .NUM_CH  (NumCh),
        .CNT_W   (8),
        .PRESC_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .out         (out),
        .period_tick (period_tick)
    );

    typedef struct {
        string          tag;
        logic [NumCh:0] exp;  // {period_tick, out}
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void push_exp(input string tag, input logic pt, input logic [NumCh-1:0] o);
        exp_t e;
        e.tag = tag;
        e.exp = {pt, o};
        sb.push_back(e);
    endfunction

    task automatic cmp_pop();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%h expected=queued_entry", {period_tick, out});
        end else begin
            e = sb.pop_front();
            assert ({period_tick, out} === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, {period_tick, out}, e.exp);
            end
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        drive(a, d);
        @(negedge clk);
        idle();
    endtask

    // Returns at the negedge sample where period_tick is seen high
    task automatic wait_ptick(input int max_cycles, input string tag);
        bit found;
        found = 1'b0;
        idle();
        for (int i = 0; i < max_cycles && !found; i++) begin
            @(negedge clk);
            if (period_tick === 1'b1) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL %s observed=no_period_tick expected=period_tick within %0d cycles",
                   tag, max_cycles);
        end
    endtask

    // Triangle-wave counter value j ticks after a center-mode boundary
    function automatic int unsigned tri_cnt(input int unsigned j, input int unsigned top);
        int unsigned t;
        t = j % (2 * top);
        return (t <= top) ? t : 2 * top - t;
    endfunction

    initial begin
        logic [NumCh-1:0] v;
        int unsigned      d;

        // Reset with a write held on the port: the write must be dropped
        rst = 1'b1;
        drive(8'h00, 8'hFF);
        repeat (3) @(negedge clk);
        push_exp("reset_state", 1'b0, '0);
        cmp_pop();
        rst = 1'b0;
        idle();
        // TOP=0 after reset: every tick is a boundary
        @(negedge clk);
        push_exp("post_reset_top0", 1'b1, '0);
        cmp_pop();

        // Unmapped / out-of-range writes, then enable everything with zero duty
        wr(8'h20, 8'hFF);
        wr(8'h0B, 8'hFF);
        wr(8'h02, 8'hFF);
        wr(8'h00, 8'hFF);
        wr(8'h01, 8'hFF);
        wr(8'h04, 8'hFF);
        wr(8'h05, 8'hFF);
        repeat (2) begin
            @(negedge clk);
            push_exp("ignored_writes", 1'b1, '0);
            cmp_pop();
        end
        wr(8'h01, 8'h00);
        wr(8'h05, 8'h00);

        // Edge mode, TOP=9, PRESC=0, ch0 duty 3
        wr(8'h09, 8'd9);
        wr(8'h10, 8'd3);
        wr(8'h04, 8'h01);
        wr(8'h00, 8'h01);
        wait_ptick(40, "edge_sync");
        wait_ptick(40, "edge_sync2");
        for (int k = 1; k <= 20; k++) begin
            push_exp("edge_duty3", (k % 10) == 0, NumCh'(((k - 1) % 10) < 3));
            @(negedge clk);
            cmp_pop();
        end

        // Duty 3->7 mid-period, then 7->2 written on the boundary cycle
        for (int k = 1; k <= 30; k++) begin
            if (k == 2) drive(8'h10, 8'd7);
            else if (k == 20) drive(8'h10, 8'd2);
            else idle();
            d = ((k - 1) / 10 == 0) ? 3 : ((k - 1) / 10 == 1) ? 7 : 2;
            push_exp("duty_update", (k % 10) == 0, NumCh'(((k - 1) % 10) < d));
            @(negedge clk);
            cmp_pop();
        end
        idle();

        // Constant cases with TOP=99
        wr(8'h09, 8'd99);
        wr(8'h11, 8'd0);
        wr(8'h12, 8'd200);
        wr(8'h14, 8'd5);
        wr(8'h00, 8'h0E);
        wr(8'h04, 8'h16);
        wait_ptick(120, "const_sync");
        for (int k = 1; k <= 105; k++) begin
            push_exp("const_levels", k == 100, 16'h000C);
            @(negedge clk);
            cmp_pop();
        end

        // Reset mid-period with a write presented during reset
        rst = 1'b1;
        drive(8'h00, 8'hFF);
        @(negedge clk);
        push_exp("mid_reset", 1'b0, '0);
        cmp_pop();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        push_exp("after_mid_reset", 1'b1, '0);
        cmp_pop();
        // ch2 had duty 200 before reset; cleared shadow/active keep it low
        wr(8'h00, 8'h04);
        wr(8'h04, 8'h04);
        repeat (3) begin
            @(negedge clk);
            push_exp("duty_cleared", 1'b1, '0);
            cmp_pop();
        end

        // Center mode, TOP=4, PRESC=1, ch5 duty 2
        wr(8'h0A, 8'h01);
        wr(8'h09, 8'd4);
        wr(8'h08, 8'd1);
        wr(8'h15, 8'd2);
        wr(8'h00, 8'h20);
        wr(8'h04, 8'h20);
        wait_ptick(100, "center_sync");
        wait_ptick(100, "center_sync2");
        for (int k = 1; k <= 32; k++) begin
            v    = '0;
            v[5] = tri_cnt((k - 1) / 2, 4) < 2;
            push_exp("center_ch5", (k % 16) == 0, v);
            @(negedge clk);
            cmp_pop();
        end

        // Edge mode TOP=50, then lower TOP to 10 when the counter reaches 30
        wr(8'h0A, 8'h00);
        wr(8'h08, 8'd0);
        wr(8'h09, 8'd50);
        wr(8'h00, 8'h00);
        wait_ptick(200, "top_sync");
        wait_ptick(200, "top_sync2");
        for (int k = 1; k <= 42; k++) begin
            if (k == 30) drive(8'h09, 8'd10);
            else idle();
            push_exp("top_lowered", (k == 31) || (k == 42), '0);
            @(negedge clk);
            cmp_pop();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=bench_completion");
        $fatal(1, "watchdog expired");
    end

endmodule
